// File: rtl/vga_timing_gen.sv
// Raster-scan timing generator: pixel counters, sync pulses, blanking and strobes.
// Every output is registered from next-state counters, so all of them describe the pixel shown on x/y.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter bit SYNC_NEG = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   // The 10-bit x/y ports cannot represent larger rasters.
   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : gen_size_check
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FRONT);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FRONT);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [9:0] xCount_q, xCount_d;
   logic [9:0] yCount_q, yCount_d;
   logic [7:0] frameCount_q, frameCount_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       displayOn_q, displayOn_d;
   logic       lineStart_q, lineStart_d;
   logic       frameStart_q, frameStart_d;
   logic       hsyncActive, vsyncActive;

   always_comb begin
      xCount_d     = xCount_q + 10'd1;
      yCount_d     = yCount_q;
      frameCount_d = frameCount_q;
      if (xCount_q == H_LAST) begin
         xCount_d = '0;
         if (yCount_q == V_LAST) begin
            yCount_d     = '0;
            frameCount_d = frameCount_q + 8'd1;
         end else begin
            yCount_d = yCount_q + 10'd1;
         end
      end

      // Decode from the next position so the registered flags line up with the registered counters.
      hsyncActive  = ({1'b0, xCount_d} >= HS_START) && ({1'b0, xCount_d} < HS_END);
      vsyncActive  = ({1'b0, yCount_d} >= VS_START) && ({1'b0, yCount_d} < VS_END);
      hsync_d      = hsyncActive ? ~SYNC_NEG : SYNC_NEG;
      vsync_d      = vsyncActive ? ~SYNC_NEG : SYNC_NEG;
      displayOn_d  = ({1'b0, xCount_d} < H_VIS) && ({1'b0, yCount_d} < V_VIS);
      lineStart_d  = (xCount_d == 10'd0);
      frameStart_d = (xCount_d == 10'd0) && (yCount_d == 10'd0);
   end

   // Reset parks at (0,0) without flagging it as a line or frame start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xCount_q     <= '0;
         yCount_q     <= '0;
         frameCount_q <= '0;
         hsync_q      <= SYNC_NEG;
         vsync_q      <= SYNC_NEG;
         displayOn_q  <= 1'b1;
         lineStart_q  <= 1'b0;
         frameStart_q <= 1'b0;
      end else begin
         xCount_q     <= xCount_d;
         yCount_q     <= yCount_d;
         frameCount_q <= frameCount_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         displayOn_q  <= displayOn_d;
         lineStart_q  <= lineStart_d;
         frameStart_q <= frameStart_d;
      end
   end

   assign x           = xCount_q;
   assign y           = yCount_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign display_on  = displayOn_q;
   assign line_start  = lineStart_q;
   assign frame_start = frameStart_q;
   assign frame_count = frameCount_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a shrunken raster (10 x 7 pixels, 70 cycles per frame)
// so that frame wrap and the 8-bit frame counter wrap fit in a short run.
module tb_vga_timing_gen;

   localparam int HA = 4, HF = 1, HS = 2, HB = 3;
   localparam int VA = 3, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       de;
      logic       ls;
      logic       fs;
      logic [7:0] fc;
   } out_t;

   typedef struct {
      bit   rstN;
      int   edges;
      out_t exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] x, y;
   logic       hsync, vsync, display_on, line_start, frame_start;
   logic [7:0] frame_count;

   int errors = 0;
   int checks = 0;
   int n = 0;
   vec_t vecs[$];

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_NEG(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .hsync(hsync), .vsync(vsync),
      .display_on(display_on), .line_start(line_start), .frame_start(frame_start),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   // Reference: everything follows from the number of counting edges since the last reset.
   function automatic out_t modelOut(int cyc);
      out_t o;
      int px, py;
      px = cyc % HT;
      py = (cyc / HT) % VT;
      o.x  = 10'(px);
      o.y  = 10'(py);
      o.hs = !(px >= HA + HF && px < HA + HF + HS);
      o.vs = !(py >= VA + VF && py < VA + VF + VS);
      o.de = (px < HA) && (py < VA);
      o.ls = (px == 0) && (cyc > 0);
      o.fs = (px == 0) && (py == 0) && (cyc > 0);
      o.fc = 8'((cyc / FRAME) % 256);
      return o;
   endfunction

   function automatic out_t actual();
      out_t o;
      o = '{x, y, hsync, vsync, display_on, line_start, frame_start, frame_count};
      return o;
   endfunction

   task automatic applyStimulus(input bit r);
      rst_n = r;
      @(posedge clk);
      n = r ? n + 1 : 0;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input out_t exp);
      out_t a;
      a = actual();
      checks++;
      if (a !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d, expected x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                  name, a.x, a.y, a.hs, a.vs, a.de, a.ls, a.fs, a.fc,
                  exp.x, exp.y, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.fc);
      end
   endtask

   task automatic checkCount(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic addVec(input bit r, input int k, input int ex, input int ey, input bit hs,
                         input bit vs, input bit de, input bit ls, input bit fs, input int fc);
      vec_t v;
      v.rstN  = r;
      v.edges = k;
      v.exp   = '{10'(ex), 10'(ey), hs, vs, de, ls, fs, 8'(fc)};
      vecs.push_back(v);
   endtask

   initial begin
      int vsLow, vsRise, deCount;
      logic prevVs;

      // Hand-computed vectors for the 10x7 raster: hsync low at x=5,6; vsync low on y=4,5.
      addVec(0, 5, 0, 0, 1, 1, 1, 0, 0, 0);
      addVec(1, 1, 1, 0, 1, 1, 1, 0, 0, 0);
      addVec(1, 4, 5, 0, 0, 1, 0, 0, 0, 0);
      addVec(1, 1, 6, 0, 0, 1, 0, 0, 0, 0);
      addVec(1, 1, 7, 0, 1, 1, 0, 0, 0, 0);
      addVec(1, 3, 0, 1, 1, 1, 1, 1, 0, 0);
      addVec(1, 1, 1, 1, 1, 1, 1, 0, 0, 0);
      addVec(1, 28, 9, 3, 1, 1, 0, 0, 0, 0);
      addVec(1, 1, 0, 4, 1, 0, 0, 1, 0, 0);
      addVec(1, 19, 9, 5, 1, 0, 0, 0, 0, 0);
      addVec(1, 1, 0, 6, 1, 1, 0, 1, 0, 0);
      addVec(1, 9, 9, 6, 1, 1, 0, 0, 0, 0);
      addVec(1, 1, 0, 0, 1, 1, 1, 1, 1, 1);
      addVec(1, 1, 1, 0, 1, 1, 1, 0, 0, 1);
      addVec(1, 22, 3, 2, 1, 1, 1, 0, 0, 1);
      addVec(0, 1, 0, 0, 1, 1, 1, 0, 0, 0);
      addVec(1, 1, 1, 0, 1, 1, 1, 0, 0, 0);

      @(negedge clk);
      foreach (vecs[i]) begin
         repeat (vecs[i].edges) applyStimulus(vecs[i].rstN);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Random run with sporadic multi-cycle resets, checked against the reference model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            repeat ($urandom_range(1, 5)) applyStimulus(1'b0);
            checkOutput("rand_reset", modelOut(n));
         end
         applyStimulus(1'b1);
         checkOutput("rand", modelOut(n));
      end

      // Mid-frame reset held for 5 cycles, then two full frames of sync/active accounting.
      while (n % FRAME != 3 * HT + 2) applyStimulus(1'b1);
      repeat (5) applyStimulus(1'b0);
      checkOutput("midframe_reset", '{10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
      vsLow = 0; vsRise = 0; deCount = 0;
      prevVs = vsync;
      if (!vsync) vsLow++;
      if (display_on) deCount++;
      for (int i = 1; i < 2 * FRAME; i++) begin
         applyStimulus(1'b1);
         if (!vsync) vsLow++;
         if (display_on) deCount++;
         if (!prevVs && vsync) begin
            vsRise++;
            checkCount("vsync_rise_x", int'(x), 0);
            checkCount("vsync_rise_y", int'(y), VA + VF + VS);
         end
         prevVs = vsync;
      end
      checkCount("vsync_low_cycles", vsLow, 2 * VS * HT);
      checkCount("vsync_rises", vsRise, 2);
      checkCount("active_cycles", deCount, 2 * HA * VA);

      // Run to the frame counter wrap, checking every cycle on the way.
      while (n < 256 * FRAME - 1) begin
         applyStimulus(1'b1);
         if (frame_start !== modelOut(n).fs || frame_count !== modelOut(n).fc)
            checkOutput("long_run", modelOut(n));
      end
      checkOutput("before_wrap", '{10'(HT - 1), 10'(VT - 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd255});
      applyStimulus(1'b1);
      checkOutput("fc_wrap", '{10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0});

      // Single-cycle reset pulse mid-line.
      repeat (4) applyStimulus(1'b1);
      checkOutput("pre_pulse", modelOut(n));
      applyStimulus(1'b0);
      checkOutput("pulse_reset", '{10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
      applyStimulus(1'b1);
      checkOutput("after_pulse", '{10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
